// File: rtl/overlay_simd_result_accumulator.sv
// SIMD lane splitter and multi-beat accumulator behind the C3x2 27x18 MAC overlay.
// Optional per-lane saturation with sticky sat_flag output: define OVERLAY_ACC_SAT_EN.
module overlay_simd_result_accumulator #(
  parameter int ACC_W = 48,
  parameter int LEN_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_signed,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               start,
  input  logic               in_valid,
  input  logic [44:0]        in_s,
  input  logic [7:0]         in_carry,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*ACC_W-1:0] out_data,
  output logic [1:0]         out_mode,
  output logic               busy,
  output logic               drop_err
`ifdef OVERLAY_ACC_SAT_EN
  ,
  output logic [3:0]         sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic               signed_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   count_q;
  logic [LEN_W-1:0]   count_inc;
  logic               last_beat;
  logic [ACC_W-1:0]   acc_q   [4];
  logic [ACC_W-1:0]   ext     [4];
  logic [ACC_W-1:0]   sum     [4];
  logic [4*ACC_W-1:0] sum_packed;
  logic [3:0]         sat_hit;
  logic [21:0]        lane22;
  logic [10:0]        lane11;
  logic               unused_carry;

  assign unused_carry = ^in_carry[7:4];

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign count_inc = count_q + 1'b1;
  assign last_beat = (count_inc == len_q);

  // Lane split and extension; unused lanes contribute zero so their sums stay 0.
  always_comb begin
    lane22 = '0;
    lane11 = '0;
    for (int unsigned k = 0; k < 4; k++) ext[k] = '0;
    case (mode_q)
      2'b01: begin
        for (int unsigned k = 0; k < 2; k++) begin
          lane22 = in_s[k*22 +: 22];
          ext[k] = signed_q ? {{(ACC_W-22){lane22[21]}}, lane22}
                            : {{(ACC_W-23){1'b0}}, in_carry[k], lane22};
        end
      end
      2'b10: begin
        for (int unsigned k = 0; k < 4; k++) begin
          lane11 = in_s[k*11 +: 11];
          ext[k] = signed_q ? {{(ACC_W-11){lane11[10]}}, lane11}
                            : {{(ACC_W-12){1'b0}}, in_carry[k], lane11};
        end
      end
      default: begin
        ext[0] = signed_q ? {{(ACC_W-45){in_s[44]}}, in_s}
                          : {{(ACC_W-46){1'b0}}, in_carry[0], in_s};
      end
    endcase
  end

`ifdef OVERLAY_ACC_SAT_EN
  logic [ACC_W:0] wide;

  always_comb begin
    wide    = '0;
    sat_hit = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (signed_q) begin
        wide   = {acc_q[k][ACC_W-1], acc_q[k]} + {ext[k][ACC_W-1], ext[k]};
        sum[k] = wide[ACC_W-1:0];
        if (wide[ACC_W] != wide[ACC_W-1]) begin
          sat_hit[k] = 1'b1;
          sum[k]     = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end else begin
        wide   = {1'b0, acc_q[k]} + {1'b0, ext[k]};
        sum[k] = wide[ACC_W-1:0];
        if (wide[ACC_W]) begin
          sat_hit[k] = 1'b1;
          sum[k]     = '1;
        end
      end
    end
  end
`else
  always_comb begin
    sat_hit = '0;
    for (int unsigned k = 0; k < 4; k++) sum[k] = acc_q[k] + ext[k];
  end
`endif

  always_comb begin
    sum_packed = '0;
    for (int unsigned k = 0; k < 4; k++) sum_packed[k*ACC_W +: ACC_W] = sum[k];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (in_valid && last_beat) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= '0;
      signed_q  <= 1'b0;
      len_q     <= '0;
      count_q   <= '0;
      out_data  <= '0;
      out_mode  <= '0;
      out_valid <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) acc_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q   <= cfg_mode;
            signed_q <= cfg_signed;
            len_q    <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
            count_q  <= '0;
            for (int unsigned k = 0; k < 4; k++) acc_q[k] <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            count_q <= count_inc;
            for (int unsigned k = 0; k < 4; k++) acc_q[k] <= sum[k];
            if (last_beat) begin
              out_data  <= sum_packed;
              out_mode  <= mode_q;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) acc_q[k] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                     drop_err <= 1'b0;
    else if (in_valid && !in_ready) drop_err <= 1'b1;
  end

`ifdef OVERLAY_ACC_SAT_EN
  always_ff @(posedge clk) begin
    if (reset)                                 sat_flag <= '0;
    else if (state_q == IDLE && start)         sat_flag <= '0;
    else if (state_q == ACCUM && in_valid)     sat_flag <= sat_flag | sat_hit;
  end
`else
  logic unused_sat;
  assign unused_sat = ^sat_hit;
`endif

endmodule
